// File: rtl/sm3_pkg.sv
// ============================================================================
// sm3_pkg : shared constants and FSM state type for the SM3 CF arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package sm3_pkg;

    localparam int c_BLK_W = 512;
    localparam int c_DIG_W = 256;

    localparam logic [c_DIG_W-1:0] c_SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEXT = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_onehot.sv
// ============================================================================
// rr_arbiter_onehot : combinational round-robin pick, first set bit at/after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_onehot #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int c_IDX_W = $clog2(NREQ);

    int                 w_sum;
    logic [c_IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the closest hit to ptr wins.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        w_sum  = 0;
        w_cand = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_sum = int'(ptr) + i;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_cand = c_IDX_W'(w_sum);
            if (req[w_cand]) begin
                gnt         = '0;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/sm3_cf_arbiter.sv
// ============================================================================
// sm3_cf_arbiter : round-robin sharing of one SM3 CF core, IV chaining per block
// Optional watchdog: define SM3_CF_ARB_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module sm3_cf_arbiter
    import sm3_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int BLK_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BLK_W-1:0]   nblk,
    input  logic [NREQ*c_BLK_W-1:0] blk_data,
    output logic [NREQ-1:0]         gnt,
    output logic [BLK_W-1:0]        blk_idx,
    output logic [NREQ-1:0]         done,
    output logic [c_DIG_W-1:0]      digest,
    output logic                    busy,
    output logic                    err,
    output logic                    cf_start,
    output logic [c_DIG_W-1:0]      cf_iv,
    output logic [c_BLK_W-1:0]      cf_block,
    input  logic [c_DIG_W-1:0]      cf_hash,
    input  logic                    cf_end
);

    localparam int c_IDX_W = $clog2(NREQ);

    state_t               r_state, w_state_nxt;
    logic [NREQ-1:0]      r_gnt, w_gnt_nxt;
    logic [c_IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [BLK_W-1:0]     r_nblk, w_nblk_nxt;
    logic [BLK_W-1:0]     r_blk_idx, w_blk_idx_nxt;
    logic [NREQ-1:0]      r_done, w_done_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_cf_start, w_cf_start_nxt;
    logic [c_DIG_W-1:0]   r_cf_iv, w_cf_iv_nxt;
    logic [c_DIG_W-1:0]   r_digest, w_digest_nxt;
    logic [c_IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;

    logic [NREQ-1:0]      w_arb_gnt;
    logic [c_IDX_W-1:0]   w_arb_idx;
    logic                 w_arb_any;
    logic [c_IDX_W-1:0]   w_ptr_adv;
    logic                 w_last_blk;
    logic                 w_timeout;

    logic [BLK_W-1:0]     w_nblk_arr [NREQ];
    logic [c_BLK_W-1:0]   w_blk_arr  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign w_nblk_arr[g] = nblk[g*BLK_W +: BLK_W];
        assign w_blk_arr[g]  = blk_data[g*c_BLK_W +: c_BLK_W];
    end

    rr_arbiter_onehot #(.NREQ(NREQ)) u_rr (
        .req (req),
        .ptr (r_rr_ptr),
        .gnt (w_arb_gnt),
        .idx (w_arb_idx),
        .any (w_arb_any)
    );

    assign w_ptr_adv  = (r_owner == c_IDX_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_last_blk = (r_blk_idx == r_nblk - BLK_W'(1));

`ifdef SM3_CF_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_err;

    assign w_timeout = (r_state == RUN) && !cf_end &&
                       (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));

    // Counter sits at zero outside RUN, so every cf_start rise restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err    <= w_timeout;
            r_to_cnt <= (r_state == RUN) ? r_to_cnt + 1'b1 : '0;
        end
    end

    assign err = r_err;
`else
    logic w_unused_to;
    assign w_unused_to = (TIMEOUT_CYC > 0);
    assign w_timeout   = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_owner_nxt    = r_owner;
        w_nblk_nxt     = r_nblk;
        w_blk_idx_nxt  = r_blk_idx;
        w_done_nxt     = '0;
        w_busy_nxt     = r_busy;
        w_cf_start_nxt = r_cf_start;
        w_cf_iv_nxt    = r_cf_iv;
        w_digest_nxt   = r_digest;
        w_rr_ptr_nxt   = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_gnt_nxt      = w_arb_gnt;
                    w_owner_nxt    = w_arb_idx;
                    w_nblk_nxt     = (w_nblk_arr[w_arb_idx] == '0) ? BLK_W'(1)
                                                                   : w_nblk_arr[w_arb_idx];
                    w_blk_idx_nxt  = '0;
                    w_cf_iv_nxt    = c_SM3_IV;
                    w_cf_start_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = RUN;
                end
            end
            RUN: begin
                if (cf_end) begin
                    w_cf_start_nxt = 1'b0;
                    w_cf_iv_nxt    = cf_hash;
                    if (w_last_blk) begin
                        w_digest_nxt = cf_hash;
                        w_done_nxt   = r_gnt;
                        w_state_nxt  = FIN;
                    end else begin
                        w_blk_idx_nxt = r_blk_idx + 1'b1;
                        w_state_nxt   = NEXT;
                    end
                end else if (w_timeout) begin
                    w_cf_start_nxt = 1'b0;
                    w_gnt_nxt      = '0;
                    w_busy_nxt     = 1'b0;
                    w_rr_ptr_nxt   = w_ptr_adv;
                    w_state_nxt    = IDLE;
                end
            end
            NEXT: begin
                w_cf_start_nxt = 1'b1;
                w_state_nxt    = RUN;
            end
            FIN: begin
                w_gnt_nxt    = '0;
                w_busy_nxt   = 1'b0;
                w_rr_ptr_nxt = w_ptr_adv;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_nblk     <= '0;
            r_blk_idx  <= '0;
            r_done     <= '0;
            r_busy     <= 1'b0;
            r_cf_start <= 1'b0;
            r_cf_iv    <= c_SM3_IV;
            r_digest   <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_nblk     <= w_nblk_nxt;
            r_blk_idx  <= w_blk_idx_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
            r_cf_start <= w_cf_start_nxt;
            r_cf_iv    <= w_cf_iv_nxt;
            r_digest   <= w_digest_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign blk_idx  = r_blk_idx;
    assign done     = r_done;
    assign busy     = r_busy;
    assign cf_start = r_cf_start;
    assign cf_iv    = r_cf_iv;
    assign digest   = r_digest;
    assign cf_block = w_blk_arr[r_owner];

endmodule

`default_nettype wire
